// File: rtl/ram_block_copy_if.sv
// Control and RAM-port bundle for ram_block_copy.
// master = the copy engine, slave = the CPU-side control plus the RAM instance.
interface ram_block_copy_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  // start is a one-cycle request that is only sampled while the engine is idle.
  // While busy is high the engine owns the RAM port. done pulses for one cycle
  // when a copy completes normally.
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   words_done;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_in;
  logic              ram_load;
  logic [DATA_W-1:0] ram_out;

  modport master (
    input  start, abort, src_base, dst_base, length, ram_out,
    output busy, done, words_done, ram_address, ram_in, ram_load
  );

  modport slave (
    output start, abort, src_base, dst_base, length, ram_out,
    input  busy, done, words_done, ram_address, ram_in, ram_load
  );
endinterface

// File: rtl/ram_block_copy.sv
// Block copy engine: reads one word, then writes it, for each word of a RAM region.
// Optional macro RAM_COPY_OVERLAP_EN enables descending (memmove-safe) copies.
module ram_block_copy #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_block_copy_if.master      bus,
  output logic [1:0]            dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W:0]   remaining;
  logic              desc;
  logic [DATA_W-1:0] hold;
  logic [ADDR_W-1:0] addr_r;
  logic              load_r;
  logic              busy_r;
  logic              done_r;
  logic [ADDR_W:0]   words_done_r;

  logic              start_desc;
  logic [ADDR_W-1:0] src_init;
  logic [ADDR_W-1:0] dst_init;
  logic [ADDR_W-1:0] src_next;
  logic [ADDR_W-1:0] dst_next;

`ifdef RAM_COPY_OVERLAP_EN
  // Unwrapped compare: the destination starts inside the source block above its base.
  logic [ADDR_W+1:0] src_end;
  assign src_end    = {2'b00, bus.src_base} + {1'b0, bus.length};
  assign start_desc = ({2'b00, bus.dst_base} > {2'b00, bus.src_base}) &&
                      ({2'b00, bus.dst_base} < src_end);
`else
  assign start_desc = 1'b0;
`endif

  assign src_init = start_desc ? bus.src_base + bus.length[ADDR_W-1:0] - PTR_ONE : bus.src_base;
  assign dst_init = start_desc ? bus.dst_base + bus.length[ADDR_W-1:0] - PTR_ONE : bus.dst_base;
  assign src_next = desc ? src_ptr - PTR_ONE : src_ptr + PTR_ONE;
  assign dst_next = desc ? dst_ptr - PTR_ONE : dst_ptr + PTR_ONE;

  // RAM port outputs are registered alongside the state so start/abort never reach it combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      remaining    <= '0;
      desc         <= 1'b0;
      hold         <= '0;
      addr_r       <= '0;
      load_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      words_done_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            src_ptr      <= src_init;
            dst_ptr      <= dst_init;
            remaining    <= bus.length;
            desc         <= start_desc;
            words_done_r <= '0;
            if (bus.length != '0) begin
              state  <= S_READ;
              busy_r <= 1'b1;
              addr_r <= src_init;
            end else begin
              state  <= S_DONE;
              done_r <= 1'b1;
            end
          end
        end
        S_READ: begin
          hold <= bus.ram_out;
          if (bus.abort) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end else begin
            state  <= S_WRITE;
            addr_r <= dst_ptr;
            load_r <= 1'b1;
          end
        end
        S_WRITE: begin
          // This edge commits the word even when abort is high, so it is always counted.
          load_r       <= 1'b0;
          src_ptr      <= src_next;
          dst_ptr      <= dst_next;
          remaining    <= remaining - CNT_ONE;
          words_done_r <= words_done_r + CNT_ONE;
          if (bus.abort) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end else if (remaining != CNT_ONE) begin
            state  <= S_READ;
            addr_r <= src_next;
          end else begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_r <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_address = addr_r;
  assign bus.ram_in      = hold;
  assign bus.ram_load    = load_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.words_done  = words_done_r;
  assign dbg_state       = state;
endmodule

// File: tb/tb_ram_block_copy.sv
// Self-checking bench for ram_block_copy: directed and random copies against a RAM model
// and an element-wise reference copy.
module tb_ram_block_copy;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int SIZE   = 1 << ADDR_W;

  logic clk;
  logic reset;
  logic [1:0] dbg_state;

  ram_block_copy_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_block_copy #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // RAM instance: asynchronous read, synchronous write; tb side-port for preloading.
  logic [DATA_W-1:0] mem     [SIZE];
  logic [DATA_W-1:0] ref_mem [SIZE];
  logic              tb_we;
  logic [ADDR_W-1:0] tb_addr;
  logic [DATA_W-1:0] tb_data;

  assign bus.ram_out = mem[bus.ram_address];

  always @(posedge clk) begin
    if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    else if (tb_we)   mem[tb_addr] <= tb_data;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_r_q[$];
  logic [31:0] exp_w_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int a, input logic [DATA_W-1:0] d);
    ref_mem[a % SIZE] = d;
    @(negedge clk);
    tb_we   = 1'b1;
    tb_addr = ADDR_W'(a % SIZE);
    tb_data = d;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  task automatic fill(input int lo, input int n);
    for (int i = 0; i < n; i++) set_word((lo + i + SIZE) % SIZE, DATA_W'($urandom));
  endtask

  task automatic cmp_win(input string tag, input int lo, input int n);
    int bad = 0;
    int a;
    for (int i = 0; i < n; i++) begin
      a = (lo + i + SIZE) % SIZE;
      if (mem[a] !== ref_mem[a]) bad++;
    end
    chk(tag, bad, 0);
  endtask

  // Reference: copy word k from src+k to dst+k one word at a time, highest k first
  // when the overlap feature selects a descending copy.
  task automatic model_copy(input int src, input int dst, input int len, input int nwords);
    bit desc = 1'b0;
    int k;
    int s;
    int d;
    exp_r_q.delete();
    exp_w_q.delete();
`ifdef RAM_COPY_OVERLAP_EN
    desc = (dst > src) && (dst < src + len);
`endif
    for (int i = 0; i < nwords; i++) begin
      k = desc ? len - 1 - i : i;
      s = (src + k) % SIZE;
      d = (dst + k) % SIZE;
      ref_mem[d] = ref_mem[s];
      exp_r_q.push_back(s);
      exp_w_q.push_back(d);
    end
  endtask

  task automatic run_copy(input string name, input int src, input int dst, input int len,
                          input int abort_at, input int reset_at, input int poke_at);
    int nwords;
    int last_busy;
    int done_cyc = -1;
    int done_cnt = 0;
    int busy_bad = 0;
    int rd_bad   = 0;
    int wr_bad   = 0;
    bit fin      = 1'b0;
    logic [31:0] got_r[$];
    logic [31:0] got_w[$];

    nwords = len;
    if (abort_at > 0) nwords = abort_at / 2;
    if (reset_at > 0) nwords = (reset_at - 1) / 2;
    last_busy = (abort_at > 0) ? abort_at : 2 * len;
    model_copy(src, dst, len, nwords);

    @(negedge clk);
    bus.src_base = ADDR_W'(src);
    bus.dst_base = ADDR_W'(dst);
    bus.length   = (ADDR_W+1)'(len);
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;

    for (int cyc = 1; cyc <= 2 * len + 8 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == reset_at) begin
        reset = 1'b1;
        #1;
        chk({name, "_rst_load"}, bus.ram_load, 0);
        chk({name, "_rst_busy"}, bus.busy, 0);
        chk({name, "_rst_done"}, bus.done, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({name, "_post_addr"}, bus.ram_address, 0);
        chk({name, "_post_in"}, bus.ram_in, 0);
        chk({name, "_post_load"}, bus.ram_load, 0);
        chk({name, "_post_wdone"}, bus.words_done, 0);
        fin = 1'b1;
      end else begin
        if (bus.busy !== (cyc <= last_busy)) busy_bad++;
        if (bus.done === 1'b1) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (bus.ram_load === 1'b1) got_w.push_back(bus.ram_address);
        else if (bus.busy === 1'b1) got_r.push_back(bus.ram_address);
        if (cyc == abort_at) bus.abort = 1'b1;
        if (cyc == abort_at + 1) bus.abort = 1'b0;
        if (cyc == poke_at) begin
          bus.start    = 1'b1;
          bus.src_base = ~ADDR_W'(src);
          bus.length   = (ADDR_W+1)'(1);
        end
        if (cyc == poke_at + 1) bus.start = 1'b0;
        if (abort_at == 0 && done_cyc > 0 && cyc == done_cyc + 1) fin = 1'b1;
        if (abort_at > 0 && cyc == abort_at + 3) fin = 1'b1;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;

    if (reset_at == 0) begin
      chk({name, "_done_cyc"}, done_cyc, (abort_at > 0) ? -1 : 2 * len + 1);
      chk({name, "_done_cnt"}, done_cnt, (abort_at > 0) ? 0 : 1);
      chk({name, "_busy"}, busy_bad, 0);
      chk({name, "_words_done"}, bus.words_done, nwords);
      if (got_r.size() != exp_r_q.size()) rd_bad++;
      else foreach (got_r[i]) if (got_r[i] !== exp_r_q[i]) rd_bad++;
      if (got_w.size() != exp_w_q.size()) wr_bad++;
      else foreach (got_w[i]) if (got_w[i] !== exp_w_q[i]) wr_bad++;
      chk({name, "_rd_addr"}, rd_bad, 0);
      chk({name, "_wr_addr"}, wr_bad, 0);
    end
    cmp_win({name, "_src_mem"}, src - 2, len + 4);
    cmp_win({name, "_dst_mem"}, dst - 2, len + 4);
  endtask

  initial begin
    int src;
    int dst;
    int len;
    reset        = 1'b1;
    tb_we        = 1'b0;
    tb_addr      = '0;
    tb_data      = '0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.src_base = '0;
    bus.dst_base = '0;
    bus.length   = '0;
    repeat (2) @(negedge clk);
    chk("reset_addr", bus.ram_address, 0);
    chk("reset_in", bus.ram_in, 0);
    chk("reset_load", bus.ram_load, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_wdone", bus.words_done, 0);
    reset = 1'b0;

    // Abort while idle has no effect.
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("idle_abort_busy", bus.busy, 0);

    // Basic four-word copy.
    fill(16'h0100 - 2, 8);
    fill(16'h0200 - 2, 8);
    for (int i = 0; i < 4; i++) set_word(16'h0100 + i, DATA_W'(i + 1));
    run_copy("basic", 16'h0100, 16'h0200, 4, 0, 0, 0);
    chk("basic_word3", mem[16'h0203], 4);

    // Zero length.
    fill(16'h0300 - 2, 4);
    fill(16'h0400 - 2, 4);
    run_copy("zero", 16'h0300, 16'h0400, 0, 0, 0, 0);

    // Source wraps past the top of RAM.
    fill(16'h3FFE - 2, 8);
    fill(16'h0010 - 2, 8);
    run_copy("wrap", 16'h3FFE, 16'h0010, 4, 0, 0, 0);

    // Abort during the write of word 3; start poked while busy is ignored.
    fill(16'h0500 - 2, 12);
    fill(16'h0600 - 2, 12);
    run_copy("abort", 16'h0500, 16'h0600, 8, 6, 0, 3);

    // Overlapping forward copy.
    fill(0, 8);
    for (int i = 0; i < 4; i++) set_word(i, DATA_W'(16'hA0 + i));
    run_copy("overlap", 0, 2, 4, 0, 0, 0);

    // Reset in the middle of a copy.
    fill(16'h0700 - 2, 10);
    fill(16'h0800 - 2, 10);
    run_copy("midreset", 16'h0700, 16'h0800, 6, 0, 4, 0);

    // Random copies, half of them forward-overlapping.
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 40);
      src = $urandom_range(0, SIZE - 1);
      if (t % 2 == 0) dst = (src + $urandom_range(1, len)) % SIZE;
      else            dst = $urandom_range(0, SIZE - 1);
      fill(src - 2, len + 4);
      fill(dst - 2, len + 4);
      run_copy("random", src, dst, len, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
